// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: fetch (if) and load/store (d) share one memory port; d wins ties unless fetch starved MAX_WAIT cycles.
// Latency: grant and memory request are combinational; read response exactly one cycle after a read grant.
// Backpressure: losing requester sees gnt low and stall high; it may hold or drop req freely.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic [15:0]       conflict_cnt
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic [3:0] wait_nxt;
    owner_t     owner;
    owner_t     owner_nxt;

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!reset) begin
            if (if_req && d_req) begin
                if (wait_cnt == MAX_WAIT_L) if_gnt = 1'b1;
                else                        d_gnt  = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    // Fetch carries no write data, so mem_wdata is only driven on a d grant.
    always_comb begin
        mem_en    = if_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    assign stall = !reset && ((if_req && !if_gnt) || (d_req && !d_gnt));

    always_comb begin
        wait_nxt = 4'd0;
        if (if_req && !if_gnt) begin
            wait_nxt = (wait_cnt < MAX_WAIT_L) ? wait_cnt + 4'd1 : wait_cnt;
        end
    end

    always_comb begin
        owner_nxt = OWN_NONE;
        if (if_gnt)              owner_nxt = OWN_IF;
        else if (d_gnt && !d_we) owner_nxt = OWN_D;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt     <= 4'd0;
            owner        <= OWN_NONE;
            conflict_cnt <= 16'd0;
        end else begin
            wait_cnt <= wait_nxt;
            owner    <= owner_nxt;
            if (if_req && d_req && conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

    // Gating with reset kills a response whose grant preceded the reset cycle.
    assign if_rvalid = (owner == OWN_IF) && !reset;
    assign d_rvalid  = (owner == OWN_D) && !reset;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic          if_gnt, if_rvalid, d_gnt, d_rvalid;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic          mem_en, mem_we, stall;
    logic [AW-1:0] mem_addr;
    logic [15:0]   conflict_cnt;

    int total = 0;
    int bad   = 0;

    // reference model state: denied-fetch streak, conflict tally, pending responses
    int streak = 0;
    int m_conf = 0;
    bit pend_if = 0;
    bit pend_d  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall(stall), .conflict_cnt(conflict_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs already driven; checks one cycle and advances the model.
    task automatic step();
        bit e_if, e_d, e_stall;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        #1;
        e_if = 0;
        e_d  = 0;
        if (!reset) begin
            if (if_req && d_req) begin
                e_if = (streak == MW);
                e_d  = !e_if;
            end else begin
                e_if = if_req;
                e_d  = d_req;
            end
        end
        e_stall = !reset && ((if_req && !e_if) || (d_req && !e_d));
        e_addr  = e_if ? if_addr : (e_d ? d_addr : '0);
        e_wdata = e_d ? d_wdata : '0;
        chk("if_gnt", if_gnt, e_if);
        chk("d_gnt", d_gnt, e_d);
        chk("mem_en", mem_en, e_if | e_d);
        chk("mem_we", mem_we, e_d & d_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("stall", stall, e_stall);
        chk("if_rvalid", if_rvalid, pend_if && !reset);
        chk("d_rvalid", d_rvalid, pend_d && !reset);
        chk("if_rdata", if_rdata, (pend_if && !reset) ? mem_rdata : '0);
        chk("d_rdata", d_rdata, (pend_d && !reset) ? mem_rdata : '0);
        chk("conflict_cnt", conflict_cnt, m_conf);
        @(posedge clk);
        if (reset) begin
            streak  = 0;
            m_conf  = 0;
            pend_if = 0;
            pend_d  = 0;
        end else begin
            if (if_req && d_req && m_conf < 65535) m_conf++;
            streak  = (if_req && !e_if) ? streak + 1 : 0;
            pend_if = e_if;
            pend_d  = e_d && !d_we;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        reset = 0; if_req = 0; d_req = 0; d_we = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1; if_req = 1; d_req = 1;
        step();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        @(posedge clk);
        @(negedge clk);

        // reset state with both requests high: no grants, no stall
        if_req = 1; d_req = 1;
        #1;
        chk("rst_if_gnt", if_gnt, 1'b0);
        chk("rst_d_gnt", d_gnt, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_conflict", conflict_cnt, 16'd0);
        step();
        idle_inputs();
        #1;
        chk("post_rst_if_rvalid", if_rvalid, 1'b0);
        chk("post_rst_d_rvalid", d_rvalid, 1'b0);
        step();

        // single fetch and its response
        if_req = 1; if_addr = 32'h10;
        #1;
        chk("fetch_gnt", if_gnt, 1'b1);
        chk("fetch_addr", mem_addr, 32'h10);
        chk("fetch_we", mem_we, 1'b0);
        step();
        idle_inputs();
        mem_rdata = 32'hE3A01005;
        #1;
        chk("fetch_rvalid", if_rvalid, 1'b1);
        chk("fetch_rdata", if_rdata, 32'hE3A01005);
        chk("fetch_no_d_rvalid", d_rvalid, 1'b0);
        step();

        // starvation guard: d wins 4 times, fetch forced on the 5th, then d again
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if_req = 1; d_req = 1; d_we = 0;
            if_addr = 32'h100 + i; d_addr = 32'h200 + i;
            mem_rdata = $urandom;
            #1;
            chk("starve_if_gnt", if_gnt, i == 4);
            chk("starve_d_gnt", d_gnt, i != 4);
            chk("starve_stall", stall, 1'b1);
            step();
        end
        idle_inputs();
        #1;
        chk("conflict_after6", conflict_cnt, 16'd6);
        step();

        // store: writes memory, never responds
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h55;
        #1;
        chk("store_en", mem_en, 1'b1);
        chk("store_we", mem_we, 1'b1);
        chk("store_addr", mem_addr, 32'h40);
        chk("store_wdata", mem_wdata, 32'h55);
        step();
        idle_inputs();
        mem_rdata = 32'h1234;
        #1;
        chk("store_no_rvalid", d_rvalid | if_rvalid, 1'b0);
        step();

        // load granted, then reset in the response cycle
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h80;
        #1;
        chk("load_gnt", d_gnt, 1'b1);
        step();
        reset = 1; d_req = 1; if_req = 1; d_we = 0; mem_rdata = 32'hAB;
        #1;
        chk("load_rst_rvalid", d_rvalid, 1'b0);
        chk("load_rst_if_gnt", if_gnt, 1'b0);
        chk("load_rst_d_gnt", d_gnt, 1'b0);
        step();
        idle_inputs();
        #1;
        chk("load_rst_conflict", conflict_cnt, 16'd0);
        step();

        // alternating fetch/load, back to back
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            if (i % 2 == 0) begin if_req = 1; if_addr = $urandom; end
            else begin d_req = 1; d_addr = $urandom; end
            mem_rdata = $urandom;
            step();
        end

        // random traffic with occasional reset
        for (int i = 0; i < 2000; i++) begin
            reset     = ($urandom_range(0, 63) == 0);
            if_req    = $urandom_range(0, 1);
            d_req     = $urandom_range(0, 1);
            d_we      = $urandom_range(0, 1);
            if_addr   = $urandom;
            d_addr    = $urandom;
            d_wdata   = $urandom;
            mem_rdata = $urandom;
            step();
        end

        // conflict counter saturation
        do_reset();
        for (int i = 0; i < 65540; i++) begin
            if_req = 1; d_req = 1; d_we = $urandom_range(0, 1);
            if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
            mem_rdata = $urandom;
            step();
        end
        #1;
        chk("conflict_saturated", conflict_cnt, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
